// File: rtl/risc_ctrl_pkg.sv
// risc_ctrl_pkg
// Shared definitions for the decode/execute control path. This package holds the
// bit layout of the packed control bundle, the bubble value and pack/unpack helpers,
// so every pipeline stage agrees on a single layout. It also holds the per-edge
// action encoding used by ctrl_flush_stage.
//
// Control bundle layout, LSB first:
//   regDst[1:0], bra[4:2] (gt/le/eq), memRead[5], memToReg[21:6], aluOp[24:22],
//   memWrite[25], regWrite[26], jump[27], seOp[28], fwdRegSource[29]
package risc_ctrl_pkg;

  localparam int CTRL_W_DEFAULT = 30;

  localparam int REGDST_LSB   = 0;
  localparam int REGDST_W     = 2;
  localparam int BRA_LSB      = 2;
  localparam int BRA_W        = 3;
  localparam int MEMREAD_BIT  = 5;
  localparam int MEMTOREG_LSB = 6;
  localparam int MEMTOREG_W   = 16;
  localparam int ALUOP_LSB    = 22;
  localparam int ALUOP_W      = 3;
  localparam int MEMWRITE_BIT = 25;
  localparam int REGWRITE_BIT = 26;
  localparam int JUMP_BIT     = 27;
  localparam int SEOP_BIT     = 28;
  localparam int FWDSRC_BIT   = 29;

  // A bubble clears every write enable and every branch/jump bit. All-zero is the
  // simplest value that does this.
  localparam logic [CTRL_W_DEFAULT-1:0] BUBBLE_CTRL = '0;

  typedef struct packed {
    logic                  fwdRegSource;
    logic                  seOp;
    logic                  jump;
    logic                  regWrite;
    logic                  memWrite;
    logic [ALUOP_W-1:0]    aluOp;
    logic [MEMTOREG_W-1:0] memToReg;
    logic                  memRead;
    logic [BRA_W-1:0]      bra;
    logic [REGDST_W-1:0]   regDst;
  } ctrl_fields_t;

  // Decides what the stage register does on a given edge.
  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_SQUASH
  } stage_act_e;

  function automatic logic [CTRL_W_DEFAULT-1:0] packCtrl(input ctrl_fields_t f);
    logic [CTRL_W_DEFAULT-1:0] v;
    v = '0;
    v[REGDST_LSB +: REGDST_W]     = f.regDst;
    v[BRA_LSB +: BRA_W]           = f.bra;
    v[MEMREAD_BIT]                = f.memRead;
    v[MEMTOREG_LSB +: MEMTOREG_W] = f.memToReg;
    v[ALUOP_LSB +: ALUOP_W]       = f.aluOp;
    v[MEMWRITE_BIT]               = f.memWrite;
    v[REGWRITE_BIT]               = f.regWrite;
    v[JUMP_BIT]                   = f.jump;
    v[SEOP_BIT]                   = f.seOp;
    v[FWDSRC_BIT]                 = f.fwdRegSource;
    return v;
  endfunction

  function automatic ctrl_fields_t unpackCtrl(input logic [CTRL_W_DEFAULT-1:0] v);
    ctrl_fields_t f;
    f.regDst       = v[REGDST_LSB +: REGDST_W];
    f.bra          = v[BRA_LSB +: BRA_W];
    f.memRead      = v[MEMREAD_BIT];
    f.memToReg     = v[MEMTOREG_LSB +: MEMTOREG_W];
    f.aluOp        = v[ALUOP_LSB +: ALUOP_W];
    f.memWrite     = v[MEMWRITE_BIT];
    f.regWrite     = v[REGWRITE_BIT];
    f.jump         = v[JUMP_BIT];
    f.seOp         = v[SEOP_BIT];
    f.fwdRegSource = v[FWDSRC_BIT];
    return f;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears q
//   inc   - add one on this edge (ignored once saturated)
//   clr   - synchronous clear, takes priority over inc
//   q     - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Saturate at all-ones so a long flush storm reads as "at least this many".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/ctrl_flush_stage.sv
// ctrl_flush_stage
// Decode-to-execute control pipeline register with flush, stall hold and a
// multi-slot squash. A flush kills the slot that is currently being loaded. It then
// kills the next SQUASH_SLOTS-1 instruction slots as well, so a branch resolved deep
// in the pipe removes every wrong-path instruction behind it.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   stall       - hold the stage contents (also freezes the squash count)
//   flush       - kill request from branch/jump resolution
//   in_valid    - decode slot holds a real instruction
//   ctrl_in     - control bundle from the control unit
//   data_in     - side data (PC+1 or immediate)
//   ctrl_q      - registered control bundle to EX
//   data_q      - registered side data
//   valid_q     - ctrl_q belongs to a live instruction
//   squashing   - squash counter non-zero
//   flush_count - saturating count of flush cycles
module ctrl_flush_stage
  import risc_ctrl_pkg::*;
#(
  parameter int                CTRL_W       = CTRL_W_DEFAULT,
  parameter int                DATA_W       = 16,
  parameter logic [CTRL_W-1:0] BUBBLE       = {CTRL_W{1'b0}},
  parameter int                SQUASH_SLOTS = 1,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [DATA_W-1:0] data_q,
  output logic              valid_q,
  output logic              squashing,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int SQ_W_RAW = $clog2(SQUASH_SLOTS + 1);
  localparam int SQ_W     = (SQ_W_RAW < 1) ? 1 : SQ_W_RAW;
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_SLOTS - 1);

  if (SQUASH_SLOTS < 1 || SQUASH_SLOTS > 7 || CTRL_W < 1 || CNT_W < 1) begin : gParamCheck
    $error("ctrl_flush_stage: illegal parameters (SQUASH_SLOTS 1..7, CTRL_W>=1, CNT_W>=1)");
  end

  logic [SQ_W-1:0]   squashCnt_q;
  logic [SQ_W-1:0]   squashCnt_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d;
  stage_act_e        act;

  // Pick the action for this edge. Flush outranks everything. A pending squash
  // outranks a load, but a stall freezes it because the squash counts instruction
  // slots rather than cycles.
  always_comb begin
    act = ACT_LOAD;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (stall) begin
      act = ACT_HOLD;
    end else if (squashCnt_q != '0) begin
      act = ACT_SQUASH;
    end
  end

  // Next-state values. data_q survives bubbles so that it only changes on a real
  // load. A load with in_valid low still writes BUBBLE, which keeps valid_q=0
  // consistent with ctrl_q==BUBBLE.
  always_comb begin
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    valid_d     = valid_q;
    squashCnt_d = squashCnt_q;
    case (act)
      ACT_FLUSH: begin
        ctrl_d      = BUBBLE;
        valid_d     = 1'b0;
        squashCnt_d = SQ_LOAD;
      end
      ACT_SQUASH: begin
        ctrl_d      = BUBBLE;
        valid_d     = 1'b0;
        squashCnt_d = squashCnt_q - SQ_W'(1);
      end
      ACT_LOAD: begin
        ctrl_d  = in_valid ? ctrl_in : BUBBLE;
        data_d  = data_in;
        valid_d = in_valid;
      end
      default: begin
      end
    endcase
  end

  // Stage register. Reset drops any squash in progress so that no bubbles carry
  // across reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= BUBBLE;
      data_q      <= '0;
      valid_q     <= 1'b0;
      squashCnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      squashCnt_q <= squashCnt_d;
    end
  end

  assign squashing = (squashCnt_q != '0);

  sat_counter #(
    .W(CNT_W)
  ) uFlushCount (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (flush),
    .clr  (1'b0),
    .q    (flush_count)
  );

endmodule

// File: tb/tb_ctrl_flush_stage.sv
// tb_ctrl_flush_stage
// Drives two instances from the same inputs:
//   A: SQUASH_SLOTS=3, CNT_W=16
//   B: SQUASH_SLOTS=1, CNT_W=2
// Each instance is compared every cycle against a slot-level reference model.
module tb_ctrl_flush_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic [29:0] ctrlIn = '0;
  logic [15:0] dataIn = '0;

  logic [29:0] ctrlA, ctrlB;
  logic [15:0] dataA, dataB;
  logic        validA, validB, squashA, squashB;
  logic [15:0] countA;
  logic [1:0]  countB;

  int totalCount = 0;
  int badCount = 0;

  // Reference state, index 0 = instance A, 1 = instance B
  int          slotsPerFlush[2] = '{3, 1};
  int          countMax[2]      = '{65535, 3};
  logic [29:0] mCtrl[2];
  logic [15:0] mData[2];
  logic        mValid[2];
  int          mKillLeft[2];
  int          mFlushes[2];

  always #5 clk = ~clk;

  ctrl_flush_stage #(.CTRL_W(30), .DATA_W(16), .SQUASH_SLOTS(3), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(inValid),
    .ctrl_in(ctrlIn), .data_in(dataIn), .ctrl_q(ctrlA), .data_q(dataA),
    .valid_q(validA), .squashing(squashA), .flush_count(countA)
  );

  ctrl_flush_stage #(.CTRL_W(30), .DATA_W(16), .SQUASH_SLOTS(1), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(inValid),
    .ctrl_in(ctrlIn), .data_in(dataIn), .ctrl_q(ctrlB), .data_q(dataB),
    .valid_q(validB), .squashing(squashB), .flush_count(countB)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mCtrl[i] = '0; mData[i] = '0; mValid[i] = 1'b0;
      mKillLeft[i] = 0; mFlushes[i] = 0;
    end
  endtask

  // One clock edge of the reference model. The rules are written per instruction
  // slot: a flush kills this slot and schedules (slots-1) more kills. A stalled
  // slot is neither loaded nor killed.
  task automatic modelEdge(input logic s, input logic f, input logic v,
                           input logic [29:0] c, input logic [15:0] d);
    for (int i = 0; i < 2; i++) begin
      if (f) begin
        mFlushes[i] = (mFlushes[i] + 1 > countMax[i]) ? countMax[i] : mFlushes[i] + 1;
        mCtrl[i] = '0; mValid[i] = 1'b0;
        mKillLeft[i] = slotsPerFlush[i] - 1;
      end else if (!s) begin
        if (mKillLeft[i] > 0) begin
          mCtrl[i] = '0; mValid[i] = 1'b0;
          mKillLeft[i] = mKillLeft[i] - 1;
        end else begin
          mCtrl[i] = v ? c : 30'h0; mData[i] = d; mValid[i] = v;
        end
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".A.ctrl"},  {2'b0, ctrlA}, {2'b0, mCtrl[0]});
    checkOutput({tag, ".A.data"},  {16'b0, dataA}, {16'b0, mData[0]});
    checkOutput({tag, ".A.valid"}, {31'b0, validA}, {31'b0, mValid[0]});
    checkOutput({tag, ".A.squash"}, {31'b0, squashA}, {31'b0, mKillLeft[0] != 0});
    checkOutput({tag, ".A.count"}, {16'b0, countA}, mFlushes[0]);
    checkOutput({tag, ".B.ctrl"},  {2'b0, ctrlB}, {2'b0, mCtrl[1]});
    checkOutput({tag, ".B.data"},  {16'b0, dataB}, {16'b0, mData[1]});
    checkOutput({tag, ".B.valid"}, {31'b0, validB}, {31'b0, mValid[1]});
    checkOutput({tag, ".B.squash"}, {31'b0, squashB}, {31'b0, mKillLeft[1] != 0});
    checkOutput({tag, ".B.count"}, {30'b0, countB}, mFlushes[1]);
  endtask

  // Drive inputs just after a falling edge, let one rising edge occur, then check
  // on the following falling edge.
  task automatic applyStimulus(input string tag, input logic s, input logic f, input logic v,
                               input logic [29:0] c, input logic [15:0] d);
    stall = s; flush = f; inValid = v; ctrlIn = c; dataIn = d;
    @(posedge clk);
    modelEdge(s, f, v, c, d);
    @(negedge clk);
    checkAll(tag);
  endtask

  // Asynchronous reset pulse in the middle of a low clock phase. The check takes
  // place before any clock edge, and reset is released on a falling edge.
  task automatic pulseReset(input string tag);
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkAll(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [29:0] rc;
  logic [15:0] rd;

  initial begin
    $display("[TB] start");
    #1 rst_n = 1'b0;
    #1 modelReset();
    checkAll("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset and load
    applyStimulus("load", 1'b0, 1'b0, 1'b1, 30'h2AAA_5555, 16'h1234);
    checkOutput("loadCtrlAbs", {2'b0, ctrlA}, 32'h2AAA_5555);
    checkOutput("loadValidAbs", {31'b0, validA}, 32'd1);

    // Stall hold
    applyStimulus("hold0", 1'b0, 1'b0, 1'b1, 30'h0000_0F0F, 16'h0F0F);
    for (int i = 0; i < 3; i++)
      applyStimulus("hold", 1'b1, 1'b0, 1'b1, 30'h1000_0000 + 30'(i), 16'(i));
    checkOutput("holdCtrlAbs", {2'b0, ctrlA}, 32'h0000_0F0F);
    applyStimulus("holdRel", 1'b0, 1'b0, 1'b1, 30'h0333_3333, 16'h5A5A);

    // Multi-slot squash with valid instructions streaming
    applyStimulus("sqF", 1'b0, 1'b1, 1'b1, 30'h0111_0001, 16'h0001);
    for (int i = 0; i < 4; i++)
      applyStimulus("sq", 1'b0, 1'b0, 1'b1, 30'h0111_0010 + 30'(i), 16'h0010 + 16'(i));
    checkOutput("sqLiveAbs", {31'b0, validA}, 32'd1);

    // Stall inside a squash
    applyStimulus("stsqF", 1'b0, 1'b1, 1'b1, 30'h0222_0001, 16'h0002);
    applyStimulus("stsqS", 1'b1, 1'b0, 1'b1, 30'h0222_0002, 16'h0003);
    applyStimulus("stsqS", 1'b1, 1'b0, 1'b1, 30'h0222_0003, 16'h0004);
    for (int i = 0; i < 3; i++)
      applyStimulus("stsq", 1'b0, 1'b0, 1'b1, 30'h0222_0010 + 30'(i), 16'h0020 + 16'(i));

    // Flush beats stall; a second flush re-arms the squash
    applyStimulus("fbsF", 1'b1, 1'b1, 1'b1, 30'h0444_0001, 16'h0030);
    applyStimulus("fbs1", 1'b0, 1'b0, 1'b1, 30'h0444_0002, 16'h0031);
    applyStimulus("fbsF2", 1'b0, 1'b1, 1'b1, 30'h0444_0003, 16'h0032);
    for (int i = 0; i < 3; i++)
      applyStimulus("fbs", 1'b0, 1'b0, 1'b1, 30'h0444_0010 + 30'(i), 16'h0040 + 16'(i));

    // Saturation on the 2-bit counter, followed by a mid-run asynchronous reset
    pulseReset("preSat");
    for (int i = 0; i < 6; i++)
      applyStimulus("sat", 1'b0, 1'b1, 1'b1, 30'h0555_0000 + 30'(i), 16'(i));
    checkOutput("satAbs", {30'b0, countB}, 32'd3);
    applyStimulus("satF", 1'b0, 1'b1, 1'b1, 30'h0555_0100, 16'h0100);
    pulseReset("satRst");

    // Randomized traffic, with an occasional reset
    for (int n = 0; n < 400; n++) begin
      rc = 30'($urandom);
      rd = 16'($urandom);
      applyStimulus("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) != 0), rc, rd);
      if (n % 150 == 149) pulseReset("rndRst");
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
